// File: rtl/stp_counter.sv
// stp_counter: step-timing up-counter with sync clear, async reset and terminal count.
// Define STP_COUNTER_SAT_EN to saturate at max instead of wrapping.
module stp_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             reset1_n,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc
);
  logic [WIDTH-1:0] cnt = '0;
  logic             at_max;
  logic [WIDTH-1:0] cnt_inc;
  assign at_max = (cnt == {WIDTH{1'b1}});
`ifdef STP_COUNTER_SAT_EN
  assign cnt_inc = at_max ? cnt : cnt + 1'b1;
`else
  assign cnt_inc = cnt + 1'b1;
`endif
  always_ff @(posedge clk_50 or negedge reset_n)
    if (!reset_n)       cnt <= '0;
    else if (!reset1_n) cnt <= '0;
    else if (en)        cnt <= cnt_inc;
  assign q  = cnt;
  assign tc = en & at_max;
endmodule

// File: tb/tb_stp_counter.sv
// tb_stp_counter: directed table-driven bench for stp_counter at WIDTH 32 and 8.
module tb_stp_counter;
  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        r1_32 = 1'b1, en_32 = 1'b0, r1_8 = 1'b1, en_8 = 1'b0;
  logic [31:0] q32;
  logic        tc32;
  logic [7:0]  q8;
  logic        tc8;
  int          checks = 0, failures = 0;

  typedef struct {logic r1; logic en; int n; logic [31:0] q;} vec_t;
  vec_t v[6];

  stp_counter #(.WIDTH(32)) u32 (.clk_50(clk_50), .reset_n(reset_n), .reset1_n(r1_32), .en(en_32), .q(q32), .tc(tc32));
  stp_counter #(.WIDTH(8))  u8  (.clk_50(clk_50), .reset_n(reset_n), .reset1_n(r1_8),  .en(en_8),  .q(q8),  .tc(tc8));

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk_50);
    #1;
  endtask

  task automatic step32(input logic r1, input logic e);
    r1_32 = r1;
    en_32 = e;
    edge_wait();
  endtask

  initial begin
    logic [7:0] exp8;
    v[0] = '{1'b0, 1'b0, 1,  32'd0};
    v[1] = '{1'b1, 1'b1, 10, 32'd10};
    v[2] = '{1'b1, 1'b0, 5,  32'd10};
    v[3] = '{1'b1, 1'b1, 10, 32'd20};
    v[4] = '{1'b0, 1'b1, 1,  32'd0};
    v[5] = '{1'b1, 1'b1, 1,  32'd1};

    // reset state, held through clock edges with en high
    #5;
    chk("reset_q32", q32, 0);
    chk("reset_tc32", tc32, 0);
    chk("reset_q8", q8, 0);
    en_32 = 1'b1;
    en_8  = 1'b1;
    repeat (2) edge_wait();
    chk("reset_hold_q32", q32, 0);
    chk("reset_hold_tc8", tc8, 0);
    en_32 = 1'b0;
    en_8  = 1'b0;
    reset_n = 1'b1;

    // async reset mid-count at q=37, then restart
    repeat (37) step32(1'b1, 1'b1);
    chk("count_37", q32, 37);
    #5 reset_n = 1'b0;
    #1 chk("async_reset_q", q32, 0);
    chk("async_reset_tc", tc32, 0);
    #2 reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step32(1'b1, 1'b1);
      chk("restart_after_reset", q32, i);
    end

    // table: count, hold, clear-beats-en, resume
    for (int k = 0; k < 6; k++) begin
      repeat (v[k].n) step32(v[k].r1, v[k].en);
      chk($sformatf("vec%0d_q", k), q32, v[k].q);
      chk($sformatf("vec%0d_tc", k), tc32, 0);
    end

    // period loop with reset1_n = (q < 5)
    step32(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      r1_32 = (q32 < 5);
      en_32 = 1'b1;
      edge_wait();
      chk($sformatf("period_%0d", i), q32, (i + 1) % 6);
    end
    en_32 = 1'b0;

    // 8-bit terminal count and wrap/saturate
    r1_8 = 1'b0;
    edge_wait();
    r1_8 = 1'b1;
    en_8 = 1'b1;
    repeat (255) edge_wait();
    chk("q8_max", q8, 255);
    chk("tc8_at_max_en", tc8, 1);
    en_8 = 1'b0;
    #1 chk("tc8_at_max_no_en", tc8, 0);
    en_8 = 1'b1;
    #1 chk("tc8_at_max_en_again", tc8, 1);
    edge_wait();
`ifdef STP_COUNTER_SAT_EN
    chk("q8_after_max", q8, 255);
    chk("tc8_after_max", tc8, 1);
    edge_wait();
    chk("q8_after_max2", q8, 255);
`else
    chk("q8_after_max", q8, 0);
    chk("tc8_after_max", tc8, 0);
    edge_wait();
    chk("q8_after_max2", q8, 1);
`endif

    // en toggling every cycle
    r1_8 = 1'b0;
    en_8 = 1'b0;
    edge_wait();
    chk("q8_clear", q8, 0);
    r1_8 = 1'b1;
    exp8 = 8'd0;
    for (int i = 0; i < 20; i++) begin
      en_8 = (i % 2 == 0);
      edge_wait();
      if (en_8) exp8++;
      chk($sformatf("toggle_%0d", i), q8, exp8);
    end
    chk("toggle_final", q8, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
